// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin pop scheduler and egress arbiter.
package rr_pkg;
   localparam int NQ = 4;
   localparam int WW = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   // A programmed weight of zero stands for the largest quantum.
   function automatic logic [3:0] wt_to_credit(input logic [WW-1:0] w);
      return (w == '0) ? 4'd8 : {1'b0, w};
   endfunction
endpackage

// File: rtl/rr_next_sel.sv
// Rotating priority encoder: first requester after ptr, wrapping modulo NQ.
module rr_next_sel
   import rr_pkg::*;
(
   input  logic [NQ-1:0] req,
   input  logic [1:0]    ptr,
   output logic [1:0]    idx,
   output logic          any
);
   logic [1:0] cand;

   // Walk from farthest to nearest so the nearest requester overrides.
   always_comb begin
      idx  = ptr;
      cand = '0;
      any  = |req;
      for (int k = NQ; k >= 1; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) idx = cand;
      end
   end
endmodule

// File: rtl/rr_pop_scheduler.sv
// Weighted round-robin pop scheduler for four FIFOs with downstream backpressure.
module rr_pop_scheduler
   import rr_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [NQ-1:0]    empty,
   input  logic             dest_full,
   input  logic [NQ*WW-1:0] weight,
   output logic [NQ-1:0]    pop,
   output logic [1:0]       pop_id,
   output logic             valid,
   output logic             busy
);
   // state | meaning
   // IDLE  | no grant; picks next non-empty queue after ptr, loads its credit
   // SERVE | pops queue cur until credit runs out or the queue drains

   state_t       state_q;
   logic [1:0]   ptr_q;
   logic [1:0]   cur_q;
   logic [3:0]   credit_q;
   logic         valid_q;
   logic [1:0]   pop_id_q;

   logic [NQ-1:0] req_w;
   logic [1:0]    sel_idx;
   logic          sel_any;
   logic [WW-1:0] wt_sel;
   logic [3:0]    credit_d;

   assign req_w = ~empty;

   rr_next_sel u_next_sel (
      .req (req_w),
      .ptr (ptr_q),
      .idx (sel_idx),
      .any (sel_any)
   );

   assign wt_sel   = weight[int'(sel_idx)*WW +: WW];
   assign credit_d = credit_q - 4'd1;

   // Combinational so backpressure and drain stop popping in the same cycle.
   always_comb begin
      pop = '0;
      if (state_q == SERVE && !empty[cur_q] && !dest_full) pop[cur_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd3;
         cur_q    <= 2'd0;
         credit_q <= 4'd0;
         valid_q  <= 1'b0;
         pop_id_q <= 2'd0;
      end else begin
         valid_q <= |pop;
         if (|pop) pop_id_q <= cur_q;
         case (state_q)
            IDLE: begin
               if (sel_any) begin
                  cur_q    <= sel_idx;
                  credit_q <= wt_to_credit(wt_sel);
                  state_q  <= SERVE;
               end
            end
            SERVE: begin
               if (empty[cur_q]) begin
                  ptr_q   <= cur_q;
                  state_q <= IDLE;
               end else if (!dest_full) begin
                  credit_q <= credit_d;
                  if (credit_q == 4'd1) begin
                     ptr_q   <= cur_q;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign valid  = valid_q;
   assign pop_id = pop_id_q;
   assign busy   = (state_q == SERVE);
endmodule

// File: tb/tb_rr_pop_scheduler.sv
// Directed self-checking bench for rr_pop_scheduler.
module tb_rr_pop_scheduler;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  empty = 4'b1111;
   logic        dest_full = 1'b0;
   logic [11:0] weight = 12'h0;
   logic [3:0]  pop;
   logic [1:0]  pop_id;
   logic        valid;
   logic        busy;

   int total = 0;
   int bad   = 0;

   rr_pop_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .empty     (empty),
      .dest_full (dest_full),
      .weight    (weight),
      .pop       (pop),
      .pop_id    (pop_id),
      .valid     (valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] idx_of(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      empty     = 4'b1111;
      dest_full = 1'b0;
      reset     = 1'b1;
      next_cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      empty = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         total++;
         if (pop !== 4'b0000 || valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d pop=%b valid=%b busy=%b want 0000/0/0", i, pop, valid, busy);
         end
      end
      empty = 4'b1111;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         next_cyc();
         total++;
         if (pop !== 4'b0000 || valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_empty cyc=%0d pop=%b valid=%b busy=%b want 0000/0/0", i, pop, valid, busy);
         end
      end
   endtask

   task automatic test_equal_weights();
      logic [3:0] exp_pop [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
      do_reset();
      weight = 12'b001_001_001_001;
      empty  = 4'b0000;
      for (int i = 0; i < 9; i++) begin
         next_cyc();
         total++;
         if (pop !== exp_pop[i]) begin
            bad++;
            $display("FAIL equal_pop cyc=%0d got=%b want=%b", i, pop, exp_pop[i]);
         end
         if (i > 0) begin
            total++;
            if (valid !== (exp_pop[i-1] != 4'b0000)) begin
               bad++;
               $display("FAIL equal_valid cyc=%0d got=%b want=%b", i, valid, exp_pop[i-1] != 4'b0000);
            end
            if (exp_pop[i-1] != 4'b0000) begin
               total++;
               if (pop_id !== idx_of(exp_pop[i-1])) begin
                  bad++;
                  $display("FAIL equal_pop_id cyc=%0d got=%0d want=%0d", i, pop_id, idx_of(exp_pop[i-1]));
               end
            end
         end
      end
   endtask

   task automatic test_weighted();
      logic [3:0] exp_pop [19] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                   4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                   4'b0001};
      do_reset();
      weight = {3'd2, 3'd1, 3'd0, 3'd3};
      empty  = 4'b0000;
      for (int i = 0; i < 19; i++) begin
         next_cyc();
         total++;
         if (pop !== exp_pop[i]) begin
            bad++;
            $display("FAIL weighted_pop cyc=%0d got=%b want=%b", i, pop, exp_pop[i]);
         end
      end
   endtask

   task automatic test_early_drain();
      logic [3:0] exp_pop [5]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
      logic       exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      do_reset();
      weight = {3'd1, 3'd1, 3'd1, 3'd5};
      empty  = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         next_cyc();
         if (i == 2) empty = 4'b0001;
         #1;
         total++;
         if (pop !== exp_pop[i] || busy !== exp_busy[i]) begin
            bad++;
            $display("FAIL drain cyc=%0d pop=%b busy=%b want %b/%b", i, pop, busy, exp_pop[i], exp_busy[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] exp_pop [9] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                  4'b0000, 4'b0100, 4'b0100, 4'b0000};
      do_reset();
      weight = {3'd1, 3'd3, 3'd1, 3'd1};
      empty  = 4'b1011;
      for (int i = 0; i < 9; i++) begin
         next_cyc();
         dest_full = (i >= 1 && i <= 5);
         #1;
         total++;
         if (pop !== exp_pop[i]) begin
            bad++;
            $display("FAIL backpressure_pop cyc=%0d got=%b want=%b", i, pop, exp_pop[i]);
         end
         if (i > 0) begin
            total++;
            if (valid !== (exp_pop[i-1] != 4'b0000)) begin
               bad++;
               $display("FAIL backpressure_valid cyc=%0d got=%b want=%b", i, valid, exp_pop[i-1] != 4'b0000);
            end
         end
      end
      dest_full = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      weight = {3'd1, 3'd1, 3'd3, 3'd1};
      empty  = 4'b1101;
      next_cyc();
      total++;
      if (pop !== 4'b0010) begin
         bad++;
         $display("FAIL areset_pre_pop got=%b want=0010", pop);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (pop !== 4'b0000 || busy !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL areset_drop pop=%b busy=%b valid=%b want 0000/0/0", pop, busy, valid);
      end
      next_cyc();
      reset = 1'b0;
      empty = 4'b0000;
      next_cyc();
      total++;
      if (pop !== 4'b0001) begin
         bad++;
         $display("FAIL areset_first_q0 got=%b want=0001", pop);
      end
      next_cyc();
      total++;
      if (valid !== 1'b1 || pop_id !== 2'd0 || pop !== 4'b0000) begin
         bad++;
         $display("FAIL areset_tag valid=%b pop_id=%0d pop=%b want 1/0/0000", valid, pop_id, pop);
      end
   endtask

   initial begin
      test_reset();
      test_equal_weights();
      test_weighted();
      test_early_drain();
      test_backpressure();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rr_pop_scheduler.md
# rr_pop_scheduler

Weighted round-robin pop scheduler for the four input FIFOs of the switch mid stage. It watches the FIFO `empty` flags and downstream backpressure, and grants one FIFO at a time for a programmable quantum of pops. It drives the one-hot `pop` strobes into the FIFOs, plus a registered `valid`/`pop_id` pair that tags the word the popped FIFO presents on the following cycle.

## Interface
- `NQ`, 4: number of queues, fixed at 4 in this revision.
- `WW`, 3: per-queue weight width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `empty`  in  4  per-FIFO empty flag; bit i = FIFO i.
- `dest_full`  in  1  downstream almost-full; while high, no pop is issued.
- `weight`  in  12  quantum per queue, `weight[3i+2:3i]`; sampled only when a queue is granted.
- `pop`  out  4  one-hot pop strobe to the FIFOs (combinational).
- `pop_id`  out  2  queue index of the word presented this cycle (registered).
- `valid`  out  1  FIFO read data is valid this cycle (registered).
- `busy`  out  1  high in SERVE.

## Operation
- **Reset values:**
  - `state`=IDLE, `ptr`=3 (so queue 0 is served first), `cur`=0, `credit`=0.
  - `valid`=0, `pop_id`=0, `pop`=0, `busy`=0.
- **State machine:** two states, IDLE and SERVE.
- **IDLE:**
  - `pop`=0.
  - If `|~empty`: `cur` <= first i with `empty[i]`=0, searching `ptr+1`, `ptr+2`, … modulo 4.
  - Same edge: `credit` <= `weight[cur]`, where a weight of 0 means 8. `credit` is 4 bits.
  - Then go to SERVE.
  - If all queues are empty, stay in IDLE.
  - `dest_full` does not block the grant.
- **SERVE:**
  - `pop[cur]` = `~empty[cur] & ~dest_full`; all other `pop` bits are 0.
  - On a pop: `credit` <= `credit`−1.
  - If a pop occurs with `credit`==1: `ptr` <= `cur`, go to IDLE. The quantum is exhausted.
  - If `empty[cur]`=1: no pop; `ptr` <= `cur`, go to IDLE. The queue drained before the quantum ended.
  - If `dest_full`=1 and `empty[cur]`=0: hold; `credit` and `cur` are unchanged.
  - Simultaneous `dest_full` and `empty[cur]`: the empty rule wins and the FSM leaves SERVE.
- **Output register:** `valid` <= `|pop`; `pop_id` <= index of `pop`. `pop_id` holds its last value when `valid`=0.
- **Invariants:**
  - `pop` is never issued to a FIFO whose `empty` is high.
  - At most one `pop` bit is set.
  - A queue never receives more than 8 consecutive pops.
- **Reset mid-operation:** all state returns to its reset values immediately, and `pop` drops in the same cycle because it is decoded from `state`.

## Timing
- **Grant latency:** a FIFO going non-empty while the FSM is in IDLE is first popped 1 cycle later (IDLE→SERVE edge).
- **Bubble:** there is exactly one idle cycle (IDLE) between consecutive quanta.
- **Peak rate per turn:** a queue with weight w gets w pops in w consecutive cycles, followed by 1 bubble cycle.
- **Data latency:** `valid`/`pop_id` rise 1 cycle after the corresponding `pop`, aligned with the FIFO's registered read data.
- **Backpressure:** `dest_full` acts in the same cycle, because `pop` is combinational.
- **Rotation:** `ptr` advances only when SERVE exits. Wrap from 3 to 0 is modulo 4.

## Structure
- **Shared package `rr_pkg`:**
  - State encoding `IDLE`=1'b0, `SERVE`=1'b1.
  - `NQ`, `WW`.
  - Function `wt_to_credit` (0→8).
- **Sub-module `rr_next_sel`:** combinational rotating priority encoder. Inputs are `req[3:0]` and `ptr[1:0]`; outputs are `idx[1:0]` and `any`. It is reused later by the egress arbiter.
- **Top level:** the FSM, the `credit` counter, the `ptr`/`cur` registers, and the output register stage.

## Test plan
1. **Reset and idle:** hold `reset`=1 for 4 cycles with `empty`=0000, then keep `empty`=1111 for 10 cycles. Required: `pop`=0000, `valid`=0 and `busy`=0 throughout.
2. **Equal weights:** `weight`=all 1, `empty`=0000, `dest_full`=0. Required:
   - `pop` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
   - `pop_id` = 0, 1, 2, 3 on the `valid` cycles.
3. **Weighted:** weights q0=3, q1=0, q2=1, q3=2, all queues non-empty. Required: 3 pops of q0, 8 of q1, 1 of q2, 2 of q3, with a single bubble between each quantum.
4. **Early drain:** q0 weight 5 holding 2 words. Required: 2 pops, then `empty[0]` rises, the FSM goes to IDLE, and q1 is granted next.
5. **Backpressure:** raise `dest_full` for 5 cycles during a q2 quantum after 1 of 3 pops. Required: `pop`=0 while `dest_full` is high, then exactly 2 more q2 pops.
6. **Async reset mid-SERVE:** assert `reset` mid-cycle during a q1 pop. Required: `pop` drops immediately; after release, q0 is served first.
